sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single dut_sram port between two requesters: input-row fetch (read) and output-row writeback (write).
- One access is granted per cycle. SRAM-side signals are registered, and read data is returned with a valid strobe aligned to the fixed SRAM latency.
- Sits between the convolution controller/datapath and the SRAM, so row prefetch for the next band can overlap writeback of the previous output row.
- Write priority applies, with a streak limit that guarantees read progress.

Parameters:
- ADDR_W, 12, SRAM address width.
- DATA_W, 16, SRAM data width.
- RD_LAT, 1, cycles from SRAM address/enable registered to sram_dut_read_data valid (legal range 1..4).
- MAX_WR_STREAK, 4, max consecutive write grants while rd_req is pending (legal range 1..15).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_b  in  1  synchronous active-low reset.
- rd_req  in  1  read request; held with rd_addr stable until rd_gnt.
- rd_addr  in  ADDR_W  read address.
- rd_gnt  out  1  combinational; read accepted this cycle.
- rd_data  out  DATA_W  returned read data.
- rd_valid  out  1  rd_data valid, one cycle per granted read.
- wr_req  in  1  write request; held with wr_addr/wr_data stable until wr_gnt.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_gnt  out  1  combinational; write accepted this cycle.
- quiesce  in  1  when high, no new grants are issued.
- busy  out  1  high while any granted read is in flight or any request is pending.
- dut_sram_read_address  out  ADDR_W  registered.
- dut_sram_write_address  out  ADDR_W  registered.
- dut_sram_write_data  out  DATA_W  registered.
- dut_sram_write_enable  out  1  registered.
- sram_dut_read_data  in  DATA_W  SRAM read data.

Behaviour:
- Reset (reset_b low at a clk edge):
  - All registered outputs go to 0, rd_valid pipeline flushed, streak counter 0, state S_IDLE.
  - rd_gnt and wr_gnt are forced 0 while reset_b is low.
  - Reset mid-operation discards in-flight reads: no rd_valid after reset, even if the SRAM returns data.
- At most one of rd_gnt/wr_gnt is high per cycle. Neither is high when quiesce=1.
- States:
  - S_IDLE: no streak. wr_req wins over rd_req. A write grant moves to S_WR with streak=1. A read grant stays in S_IDLE.
  - S_WR: when wr_req && !(rd_req && streak==MAX_WR_STREAK), grant write and streak += 1 (saturating at MAX_WR_STREAK). When rd_req and streak==MAX_WR_STREAK, go to S_RD_FORCE with no grant this cycle. Otherwise, if rd_req, grant read and return to S_IDLE with streak=0. With no requests, return to S_IDLE.
  - S_RD_FORCE: grant read unconditionally (rd_req is guaranteed held), streak=0, next S_IDLE. If quiesce is high, stay here with no grant.
- The streak counter increments only on write grants while rd_req is high. A write grant with rd_req low resets the streak to 1.
- Write path:
  - wr_gnt at cycle T drives dut_sram_write_enable=1 with the address/data at T+1.
  - write_enable is 0 in every cycle without a write grant on the prior edge.
  - Address/data registers hold their last value when not written.
- Read path:
  - rd_gnt at T registers dut_sram_read_address at T+1.
  - The SRAM returns data at T+1+RD_LAT. rd_valid=1 and rd_data=sram_dut_read_data in that same cycle. rd_data is pass-through gated by rd_valid and is 0 otherwise.
  - Back-to-back read grants produce back-to-back rd_valid cycles, in order.
- Hazard: a read granted in the cycle after a write to the same address returns the new data, because the SRAM write completes before the read address is registered. No extra bypass is required.
- busy = rd_req | wr_req | (any rd_valid pipeline bit set).

Decomposition:
- Shared package sram_arb_pkg:
  - ADDR_W and DATA_W defaults.
  - State encoding: S_IDLE=2'b00, S_WR=2'b01, S_RD_FORCE=2'b10, default goes to S_IDLE.
  - Streak counter width of 4 bits.
- One sub-module, sram_rd_valid_pipe: a RD_LAT+1-deep shift register of the read-grant bit, with synchronous active-low clear, producing rd_valid. Everything else stays in sram_port_arbiter.

Test Plan:
- Lone read: rd_req=1 with rd_addr=12'h005 at T. Expect rd_gnt=1 at T, dut_sram_read_address=12'h005 at T+1, rd_valid=1 with rd_data=mem[5] at T+2 (RD_LAT=1).
- Lone write: wr_req=1 with addr=12'h100 and data=16'hABCD at T. Expect wr_gnt at T, then dut_sram_write_enable=1 with address 12'h100 and data 16'hABCD at T+1, and enable back to 0 at T+2.
- Contention: rd_req and wr_req held high continuously with MAX_WR_STREAK=4. Expect the grant pattern W,W,W,W,(none),R repeating. No read is starved beyond 5 cycles.
- Read-after-write: write 16'h1234 to 12'h010, then read 12'h010 the next cycle. Expect rd_data=16'h1234.
- Quiesce: with both requests pending, assert quiesce for 3 cycles. Expect no grants and busy=1 throughout. Grants resume the cycle after quiesce falls.
- Reset mid-read: grant a read at T, then pull reset_b low at T+1 for one cycle. Expect rd_valid=0 throughout, all SRAM outputs 0, and state S_IDLE afterward.

Source files
------------

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared widths, FSM encoding and streak helper for the SRAM
//               port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  localparam int C_ADDR_W   = 12;
  localparam int C_DATA_W   = 16;
  localparam int C_STREAK_W = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WR       = 2'b01,
    S_RD_FORCE = 2'b10
  } arb_state_t;

  typedef logic [C_STREAK_W-1:0] streak_t;

  // Saturating increment: the streak never counts past the limit.
  function automatic streak_t streak_sat_inc(input streak_t cur, input streak_t lim);
    return (cur >= lim) ? lim : cur + streak_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter_if
// Description : Requester handshakes plus the single SRAM port. The slave
//               modport is the arbiter's view; master is the surrounding
//               controller/SRAM view.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  // read requester
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  // write requester
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  // control / status
  logic              quiesce;
  logic              busy;
  // SRAM port
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [DATA_W-1:0] dut_sram_write_data;
  logic              dut_sram_write_enable;
  logic [DATA_W-1:0] sram_dut_read_data;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, quiesce, sram_dut_read_data,
    output rd_gnt, rd_data, rd_valid, wr_gnt, busy,
           dut_sram_read_address, dut_sram_write_address,
           dut_sram_write_data, dut_sram_write_enable
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, quiesce, sram_dut_read_data,
    input  rd_gnt, rd_data, rd_valid, wr_gnt, busy,
           dut_sram_read_address, dut_sram_write_address,
           dut_sram_write_data, dut_sram_write_enable
  );
endinterface
`default_nettype wire

// File: rtl/sram_rd_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sram_rd_valid_pipe
// Description : Delays the read-grant bit by RD_LAT+1 cycles so rd_valid
//               lines up with data coming back from the SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rd_valid_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset_b,
  input  logic i_gnt,
  output logic o_valid,
  output logic o_any
);

  logic [RD_LAT:0] r_pipe;

  // Shift grants toward the output; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[RD_LAT-1:0], i_gnt};
    end
  end

  assign o_valid = r_pipe[RD_LAT];
  assign o_any   = |r_pipe;

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one SRAM port between row fetch (read) and row
//               writeback (write). Writes win, but a bounded write streak
//               forces a read slot so prefetch always progresses.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = C_ADDR_W,
  parameter int DATA_W        = C_DATA_W,
  parameter int RD_LAT        = 1,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset_b,
  sram_port_arbiter_if.slave  bus
);

  localparam streak_t c_max_streak = streak_t'(MAX_WR_STREAK);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  streak_t           r_streak;
  streak_t           w_streak_nxt;
  logic              w_rd_gnt;
  logic              w_wr_gnt;
  logic              w_can_grant;
  logic              w_streak_full;
  logic              w_rd_valid;
  logic              w_pipe_any;

  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_en;

  // Grants are suppressed during reset and while quiesced.
  assign w_can_grant   = reset_b & ~bus.quiesce;
  assign w_streak_full = (r_streak == c_max_streak);

  // Grant decision and next-state/streak computation.
  always_comb begin
    w_rd_gnt     = 1'b0;
    w_wr_gnt     = 1'b0;
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    case (r_state)
      S_IDLE: begin
        if (w_can_grant) begin
          if (bus.wr_req) begin
            w_wr_gnt     = 1'b1;
            w_state_nxt  = S_WR;
            w_streak_nxt = streak_t'(1);
          end else if (bus.rd_req) begin
            w_rd_gnt     = 1'b1;
            w_streak_nxt = '0;
          end
        end
      end
      S_WR: begin
        if (w_can_grant) begin
          if (bus.wr_req && !(bus.rd_req && w_streak_full)) begin
            w_wr_gnt     = 1'b1;
            // Only a waiting reader makes the streak grow.
            w_streak_nxt = bus.rd_req ? streak_sat_inc(r_streak, c_max_streak)
                                      : streak_t'(1);
          end else if (bus.rd_req && w_streak_full) begin
            // Spend one idle cycle, then the read is granted unconditionally.
            w_state_nxt = S_RD_FORCE;
          end else if (bus.rd_req) begin
            w_rd_gnt     = 1'b1;
            w_state_nxt  = S_IDLE;
            w_streak_nxt = '0;
          end else begin
            w_state_nxt  = S_IDLE;
            w_streak_nxt = '0;
          end
        end
      end
      S_RD_FORCE: begin
        if (w_can_grant) begin
          w_rd_gnt     = 1'b1;
          w_state_nxt  = S_IDLE;
          w_streak_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_streak_nxt = '0;
      end
    endcase
  end

  // FSM state, streak counter and registered SRAM-side outputs.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_state   <= S_IDLE;
      r_streak  <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      r_wr_en  <= w_wr_gnt;
      if (w_wr_gnt) begin
        r_wr_addr <= bus.wr_addr;
        r_wr_data <= bus.wr_data;
      end
      if (w_rd_gnt) begin
        r_rd_addr <= bus.rd_addr;
      end
    end
  end

  sram_rd_valid_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_valid_pipe (
    .clk     (clk),
    .reset_b (reset_b),
    .i_gnt   (w_rd_gnt),
    .o_valid (w_rd_valid),
    .o_any   (w_pipe_any)
  );

  assign bus.rd_gnt                 = w_rd_gnt;
  assign bus.wr_gnt                 = w_wr_gnt;
  assign bus.rd_valid               = w_rd_valid;
  assign bus.rd_data                = w_rd_valid ? bus.sram_dut_read_data : '0;
  assign bus.busy                   = bus.rd_req | bus.wr_req | w_pipe_any;
  assign bus.dut_sram_read_address  = r_rd_addr;
  assign bus.dut_sram_write_address = r_wr_addr;
  assign bus.dut_sram_write_data    = r_wr_data;
  assign bus.dut_sram_write_enable  = r_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Directed self-checking bench for sram_port_arbiter with a
//               one-cycle-latency SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int ADDR_W        = 12;
  localparam int DATA_W        = 16;
  localparam int RD_LAT        = 1;
  localparam int MAX_WR_STREAK = 4;

  logic clk     = 1'b0;
  logic reset_b = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  logic [DATA_W-1:0] mem [0:4095];

  sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_port_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .RD_LAT        (RD_LAT),
    .MAX_WR_STREAK (MAX_WR_STREAK)
  ) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: preloaded with 16'h5A00 ^ addr while in reset, 1-cycle read.
  always @(posedge clk) begin
    if (!reset_b) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'(16'h5A00 ^ i);
    end else if (bus.dut_sram_write_enable) begin
      mem[bus.dut_sram_write_address] <= bus.dut_sram_write_data;
    end
    bus.sram_dut_read_data <= mem[bus.dut_sram_read_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_b = 1'b0; bus.quiesce = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 12'h033;
    bus.wr_req = 1'b1; bus.wr_addr = 12'h044; bus.wr_data = 16'h7777;
    tick(); tick(); #1;
    checks++; if (bus.rd_gnt !== 1'b0) begin errors++; $display("FAIL reset_rd_gnt got %b exp 0", bus.rd_gnt); end
    checks++; if (bus.wr_gnt !== 1'b0) begin errors++; $display("FAIL reset_wr_gnt got %b exp 0", bus.wr_gnt); end
    checks++; if (bus.dut_sram_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.dut_sram_write_enable); end
    checks++; if (bus.dut_sram_read_address !== 12'h000) begin errors++; $display("FAIL reset_raddr got %h exp 000", bus.dut_sram_read_address); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
    reset_b = 1'b1; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    tick(); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data got %h exp 0000", bus.rd_data); end
  endtask

  task automatic test_lone_read();
    tick();
    bus.rd_req = 1'b1; bus.rd_addr = 12'h005; #1;
    checks++; if (bus.rd_gnt !== 1'b1) begin errors++; $display("FAIL lone_rd_gnt got %b exp 1", bus.rd_gnt); end
    checks++; if (bus.wr_gnt !== 1'b0) begin errors++; $display("FAIL lone_rd_wr_gnt got %b exp 0", bus.wr_gnt); end
    tick();
    bus.rd_req = 1'b0; #1;
    checks++; if (bus.dut_sram_read_address !== 12'h005) begin errors++; $display("FAIL lone_rd_addr got %h exp 005", bus.dut_sram_read_address); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL lone_rd_early_valid got %b exp 0", bus.rd_valid); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL lone_rd_busy got %b exp 1", bus.busy); end
    tick(); #1;
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL lone_rd_valid got %b exp 1", bus.rd_valid); end
    checks++; if (bus.rd_data !== 16'h5A05) begin errors++; $display("FAIL lone_rd_data got %h exp 5a05", bus.rd_data); end
    tick(); #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL lone_rd_valid_end got %b exp 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL lone_rd_data_gate got %h exp 0000", bus.rd_data); end
  endtask

  task automatic test_lone_write();
    tick();
    bus.wr_req = 1'b1; bus.wr_addr = 12'h100; bus.wr_data = 16'hABCD; #1;
    checks++; if (bus.wr_gnt !== 1'b1) begin errors++; $display("FAIL lone_wr_gnt got %b exp 1", bus.wr_gnt); end
    checks++; if (bus.rd_gnt !== 1'b0) begin errors++; $display("FAIL lone_wr_rd_gnt got %b exp 0", bus.rd_gnt); end
    tick();
    bus.wr_req = 1'b0; #1;
    checks++; if (bus.dut_sram_write_enable !== 1'b1) begin errors++; $display("FAIL lone_wr_we got %b exp 1", bus.dut_sram_write_enable); end
    checks++; if (bus.dut_sram_write_address !== 12'h100) begin errors++; $display("FAIL lone_wr_addr got %h exp 100", bus.dut_sram_write_address); end
    checks++; if (bus.dut_sram_write_data !== 16'hABCD) begin errors++; $display("FAIL lone_wr_data got %h exp abcd", bus.dut_sram_write_data); end
    tick(); #1;
    checks++; if (bus.dut_sram_write_enable !== 1'b0) begin errors++; $display("FAIL lone_wr_we_end got %b exp 0", bus.dut_sram_write_enable); end
    checks++; if (bus.dut_sram_write_address !== 12'h100) begin errors++; $display("FAIL lone_wr_addr_hold got %h exp 100", bus.dut_sram_write_address); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.rd_req  = (i < 3);
      bus.rd_addr = 12'(i + 1);
      #1;
      if (i < 3) begin
        checks++; if (bus.rd_gnt !== 1'b1) begin errors++; $display("FAIL b2b_rd_gnt cycle %0d got %b exp 1", i, bus.rd_gnt); end
      end
      if (i >= 2) begin
        exp_data = 16'(16'h5A00 ^ (i - 1));
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd_valid cycle %0d got %b exp 1", i, bus.rd_valid); end
        checks++; if (bus.rd_data !== exp_data) begin errors++; $display("FAIL b2b_rd_data cycle %0d got %h exp %h", i, bus.rd_data, exp_data); end
      end else begin
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_rd_valid cycle %0d got %b exp 0", i, bus.rd_valid); end
      end
    end
    bus.rd_req = 1'b0;
  endtask

  task automatic test_contention();
    int   ph;
    logic exp_w;
    logic exp_r;
    for (int i = 0; i < 12; i++) begin
      tick();
      bus.rd_req = 1'b1; bus.rd_addr = 12'h007;
      bus.wr_req = 1'b1; bus.wr_addr = 12'h200; bus.wr_data = 16'h00C3;
      #1;
      ph    = i % 6;
      exp_w = (ph < 4);
      exp_r = (ph == 5);
      checks++; if (bus.wr_gnt !== exp_w) begin errors++; $display("FAIL contention_wr_gnt cycle %0d got %b exp %b", i, bus.wr_gnt, exp_w); end
      checks++; if (bus.rd_gnt !== exp_r) begin errors++; $display("FAIL contention_rd_gnt cycle %0d got %b exp %b", i, bus.rd_gnt, exp_r); end
    end
    tick();
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_read_after_write();
    tick();
    bus.wr_req = 1'b1; bus.wr_addr = 12'h010; bus.wr_data = 16'h1234; #1;
    checks++; if (bus.wr_gnt !== 1'b1) begin errors++; $display("FAIL raw_wr_gnt got %b exp 1", bus.wr_gnt); end
    tick();
    bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 12'h010; #1;
    checks++; if (bus.rd_gnt !== 1'b1) begin errors++; $display("FAIL raw_rd_gnt got %b exp 1", bus.rd_gnt); end
    tick();
    bus.rd_req = 1'b0;
    tick(); #1;
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL raw_rd_valid got %b exp 1", bus.rd_valid); end
    checks++; if (bus.rd_data !== 16'h1234) begin errors++; $display("FAIL raw_rd_data got %h exp 1234", bus.rd_data); end
  endtask

  task automatic test_quiesce();
    tick();
    bus.quiesce = 1'b1;
    bus.rd_req = 1'b1; bus.rd_addr = 12'h009;
    bus.wr_req = 1'b1; bus.wr_addr = 12'h300; bus.wr_data = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      checks++; if (bus.wr_gnt !== 1'b0) begin errors++; $display("FAIL quiesce_wr_gnt cycle %0d got %b exp 0", i, bus.wr_gnt); end
      checks++; if (bus.rd_gnt !== 1'b0) begin errors++; $display("FAIL quiesce_rd_gnt cycle %0d got %b exp 0", i, bus.rd_gnt); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL quiesce_busy cycle %0d got %b exp 1", i, bus.busy); end
    end
    tick();
    bus.quiesce = 1'b0; #1;
    checks++; if (bus.wr_gnt !== 1'b1) begin errors++; $display("FAIL quiesce_resume_wr got %b exp 1", bus.wr_gnt); end
    checks++; if (bus.rd_gnt !== 1'b0) begin errors++; $display("FAIL quiesce_resume_rd got %b exp 0", bus.rd_gnt); end
    tick();
    bus.wr_req = 1'b0; #1;
    checks++; if (bus.rd_gnt !== 1'b1) begin errors++; $display("FAIL quiesce_then_rd got %b exp 1", bus.rd_gnt); end
    tick();
    bus.rd_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_read();
    tick();
    bus.rd_req = 1'b1; bus.rd_addr = 12'h005; #1;
    checks++; if (bus.rd_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_rd_gnt got %b exp 1", bus.rd_gnt); end
    tick();
    reset_b = 1'b0; bus.rd_addr = 12'h006; #1;
    checks++; if (bus.rd_gnt !== 1'b0) begin errors++; $display("FAIL rstmid_gnt_forced got %b exp 0", bus.rd_gnt); end
    tick();
    reset_b = 1'b1; bus.rd_req = 1'b0; #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rd_valid got %b exp 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL rstmid_rd_data got %h exp 0000", bus.rd_data); end
    checks++; if (bus.dut_sram_read_address !== 12'h000) begin errors++; $display("FAIL rstmid_raddr got %h exp 000", bus.dut_sram_read_address); end
    checks++; if (bus.dut_sram_write_address !== 12'h000) begin errors++; $display("FAIL rstmid_waddr got %h exp 000", bus.dut_sram_write_address); end
    checks++; if (bus.dut_sram_write_data !== 16'h0000) begin errors++; $display("FAIL rstmid_wdata got %h exp 0000", bus.dut_sram_write_data); end
    checks++; if (bus.dut_sram_write_enable !== 1'b0) begin errors++; $display("FAIL rstmid_we got %b exp 0", bus.dut_sram_write_enable); end
    checks++; if (dut.r_state !== S_IDLE) begin errors++; $display("FAIL rstmid_state got %b exp %b", dut.r_state, S_IDLE); end
    tick(); #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rd_valid_late got %b exp 0", bus.rd_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
  endtask

  initial begin
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.quiesce = 1'b0;
    test_reset();
    test_lone_read();
    test_lone_write();
    test_back_to_back();
    test_contention();
    test_read_after_write();
    test_quiesce();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
